qerv_bufreg_w: RTL and testbench

QERV_BUFREG_W -- requirements
Module: qerv_bufreg_w

---
 rtl/qerv_bufreg_w.sv | 118 +++++++++++
 tb/tb_qerv_bufreg_w.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/qerv_bufreg_w.sv
// rtl/qerv_bufreg_w.sv - W-bit-per-beat serial buffer register for address/shift staging
// Accumulates rs1+imm serially, captures address LSBs, and shifts data by a sub-slice amount.
module qerv_bufreg_w #(
  parameter int W   = 4,
  parameter int MDU = 0,
  parameter int LB  = (W > 1) ? $clog2(W) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  input  logic          i_init,
  input  logic          i_rs1_en,
  input  logic          i_imm_en,
  input  logic          i_clr_lsb,
  input  logic          i_shift_op,
  input  logic          i_right_shift_op,
  input  logic          i_sh_signed,
  input  logic [LB-1:0] i_shamt_lsb,
  input  logic [1:0]    i_size,
  input  logic          i_mdu_op,
  input  logic [W-1:0]  i_rs1,
  input  logic [W-1:0]  i_imm,
  output logic [W-1:0]  o_q,
  output logic          o_last,
  output logic [1:0]    o_lsb,
  output logic          o_misalign,
  output logic [31:0]   o_dbus_adr,
  output logic [31:0]   o_ext_rs1
);

  localparam int NB = 32 / W;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  logic [CW-1:0]  r_cnt;
  logic           r_c;
  logic [31:0]    r_data;
  logic [1:0]     r_lsb;
  logic [W-1:0]   r_spill;

  logic           w_beat0;
  logic [W-1:0]   w_imm;
  logic [W-1:0]   w_rs1_g;
  logic [W-1:0]   w_imm_g;
  logic [W:0]     w_sum;
  logic [W-1:0]   w_q;
  logic           w_c;
  logic [W-1:0]   w_fill;
  logic [LB-1:0]  w_amt;
  logic [2*W-1:0] w_shift;

  assign w_beat0 = (r_cnt == '0);

  always_comb begin
    w_imm = i_imm;
    if (w_beat0 && i_clr_lsb) w_imm[0] = 1'b0;
  end

  assign w_rs1_g = i_rs1_en ? i_rs1 : '0;
  assign w_imm_g = i_imm_en ? w_imm : '0;
  assign w_sum   = {1'b0, w_rs1_g} + {1'b0, w_imm_g} + {{W{1'b0}}, r_c};
  assign w_q     = w_sum[W-1:0];
  assign w_c     = w_sum[W];

  assign w_fill = i_init ? w_q : (i_sh_signed ? {W{r_data[31]}} : '0);

  // W is a power of two, so negating modulo 2^LB yields (W - shamt) mod W
  always_comb begin
    w_amt = '0;
    if (W > 1 && i_shift_op)
      w_amt = i_right_shift_op ? ('0 - i_shamt_lsb) : i_shamt_lsb;
  end

  assign w_shift = {{W{1'b0}}, r_data[W-1:0]} << w_amt;

  assign o_q        = i_en ? (w_shift[W-1:0] | (w_beat0 ? '0 : r_spill)) : '0;
  assign o_last     = i_en & (r_cnt == CW'(NB - 1));
  assign o_lsb      = ((MDU != 0) && i_mdu_op) ? 2'b00 : r_lsb;
  assign o_misalign = ((i_size == 2'b01) & r_lsb[0]) | ((i_size == 2'b10) & (r_lsb != 2'b00));
  assign o_dbus_adr = {r_data[31:2], 2'b00};
  assign o_ext_rs1  = {r_data[31:2], r_lsb};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_c     <= 1'b0;
      r_data  <= '0;
      r_spill <= '0;
    end else begin
      r_c <= w_c & i_en;
      if (i_en) begin
        r_cnt   <= r_cnt + CW'(1);
        r_data  <= {w_fill, r_data[31:W]};
        r_spill <= w_shift[2*W-1:W];
      end
    end
  end

  // A one-bit datapath only sees one address bit per beat, so the two LSBs arrive on beats 0 and 1
  if (W == 1) begin : g_lsb_serial
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_lsb <= 2'b00;
      end else if (i_en) begin
        if (r_cnt == CW'(0)) r_lsb[0] <= w_q[0];
        if (r_cnt == CW'(1)) r_lsb[1] <= w_q[0];
      end
    end
  end else begin : g_lsb_wide
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_lsb <= 2'b00;
      end else if (i_en && w_beat0) begin
        r_lsb <= w_q[1:0];
      end
    end
  end

endmodule

// File: tb/tb_qerv_bufreg_w.sv
// tb/tb_qerv_bufreg_w.sv - scoreboard bench for qerv_bufreg_w (W=4 main, W=1/2/8 address checks)
module tb_qerv_bufreg_w;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, init, rs1_en, imm_en, clr_lsb, shift_op, rsh, sh_signed, mdu_op;
  logic [1:0]  shamt, size;
  logic [3:0]  rs1, imm;
  logic [3:0]  q;
  logic        last, mis;
  logic [1:0]  lsb;
  logic [31:0] adr, ext;

  qerv_bufreg_w #(.W(4), .MDU(0)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_init(init), .i_rs1_en(rs1_en), .i_imm_en(imm_en),
    .i_clr_lsb(clr_lsb), .i_shift_op(shift_op), .i_right_shift_op(rsh), .i_sh_signed(sh_signed),
    .i_shamt_lsb(shamt), .i_size(size), .i_mdu_op(mdu_op), .i_rs1(rs1), .i_imm(imm),
    .o_q(q), .o_last(last), .o_lsb(lsb), .o_misalign(mis), .o_dbus_adr(adr), .o_ext_rs1(ext)
  );

  int          wg [3] = '{1, 2, 8};
  logic        g_en   [3];
  logic [7:0]  g_rs1  [3];
  logic [7:0]  g_imm  [3];
  logic [7:0]  g_q    [3];
  logic        g_last [3];
  logic [1:0]  g_lsb  [3];
  logic        g_mis  [3];
  logic [31:0] g_adr  [3];
  logic [31:0] g_ext  [3];

  for (genvar g = 0; g < 3; g++) begin : g_w
    localparam int WG = (g == 0) ? 1 : ((g == 1) ? 2 : 8);
    logic [WG-1:0] w_q;
    qerv_bufreg_w #(.W(WG), .MDU(0)) u_dut (
      .i_clk(clk), .i_rst(rst), .i_en(g_en[g]), .i_init(1'b1), .i_rs1_en(1'b1), .i_imm_en(1'b1),
      .i_clr_lsb(1'b0), .i_shift_op(1'b0), .i_right_shift_op(1'b0), .i_sh_signed(1'b0),
      .i_shamt_lsb('0), .i_size(2'b00), .i_mdu_op(1'b0), .i_rs1(g_rs1[g][WG-1:0]),
      .i_imm(g_imm[g][WG-1:0]), .o_q(w_q), .o_last(g_last[g]), .o_lsb(g_lsb[g]),
      .o_misalign(g_mis[g]), .o_dbus_adr(g_adr[g]), .o_ext_rs1(g_ext[g])
    );
    assign g_q[g] = 8'(w_q);
  end

  typedef struct packed {
    logic [3:0]  q;
    logic        last;
    logic [1:0]  lsb;
    logic        mis;
    logic [31:0] adr;
    logic [31:0] ext;
  } exp_t;

  exp_t mq [$];
  exp_t gq [3][$];
  int   n_vec = 0;
  int   n_err = 0;

  logic [31:0] m_data;
  logic [1:0]  m_lsb;

  function automatic exp_t mk(logic [3:0] q_, logic last_, logic [31:0] d, logic [1:0] l, logic [1:0] sz);
    exp_t e;
    e.q    = q_;
    e.last = last_;
    e.lsb  = l;
    e.mis  = (sz == 2'b01 && l[0]) || (sz == 2'b10 && l != 2'b00);
    e.adr  = {d[31:2], 2'b00};
    e.ext  = {d[31:2], l};
    return e;
  endfunction

  // Register contents after nbits have been shifted out: old bits move down, new bits fill from the top
  function automatic logic [31:0] dat(logic [31:0] d0, logic [31:0] top, int nbits);
    logic [63:0] lo, hi;
    lo = {32'b0, d0} >> nbits;
    hi = {32'b0, top} << (32 - nbits);
    return lo[31:0] | hi[31:0];
  endfunction

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (mq.size() > 0) begin
      e = mq.pop_front();
      chk("q", 32'(q), 32'(e.q));
      chk("last", 32'(last), 32'(e.last));
      chk("lsb", 32'(lsb), 32'(e.lsb));
      chk("misalign", 32'(mis), 32'(e.mis));
      chk("dbus_adr", adr, e.adr);
      chk("ext_rs1", ext, e.ext);
    end
    for (int g = 0; g < 3; g++) begin
      if (gq[g].size() > 0) begin
        e = gq[g].pop_front();
        chk($sformatf("w%0d_q", wg[g]), 32'(g_q[g]), 32'(e.q));
        chk($sformatf("w%0d_last", wg[g]), 32'(g_last[g]), 32'(e.last));
        chk($sformatf("w%0d_lsb", wg[g]), 32'(g_lsb[g]), 32'(e.lsb));
        chk($sformatf("w%0d_misalign", wg[g]), 32'(g_mis[g]), 32'(e.mis));
        chk($sformatf("w%0d_dbus_adr", wg[g]), g_adr[g], e.adr);
        chk($sformatf("w%0d_ext_rs1", wg[g]), g_ext[g], e.ext);
      end
    end
  end

  task automatic cyc(input exp_t e);
    mq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // One 32-bit word of 8 beats; idle gaps break the carry chain, so the sum is taken per contiguous run
  task automatic run_word(input logic ini, re, ie, cl, so, rs, sg, input logic [1:0] sa, sz,
                          input logic [31:0] a, b, input bit gaps, input int rst_at);
    bit          gap [8];
    logic [31:0] opa, opb, res, msk, d0, top, qs;
    logic [1:0]  l0;
    int          s, amt;
    for (int k = 0; k < 8; k++) gap[k] = gaps && k > 0 && ($urandom_range(0, 3) == 0);
    opa = re ? a : 32'h0;
    opb = ie ? (b & ~{31'b0, cl}) : 32'h0;
    res = 32'h0;
    s = 0;
    for (int k = 0; k < 8; k++) begin
      if (k == 7 || gap[k+1]) begin
        msk = 32'(((64'd1 << (4 * (k + 1))) - 64'd1) & ~((64'd1 << (4 * s)) - 64'd1));
        res = res | (((opa & msk) + (opb & msk)) & msk);
        s = k + 1;
      end
    end
    amt = so ? (rs ? (4 - int'(sa)) % 4 : int'(sa)) : 0;
    d0  = m_data;
    l0  = m_lsb;
    qs  = d0 << amt;
    top = ini ? res : (sg ? {32{d0[31]}} : 32'h0);
    init = ini; rs1_en = re; imm_en = ie; clr_lsb = cl; shift_op = so; rsh = rs;
    sh_signed = sg; shamt = sa; size = sz; mdu_op = 1'($urandom);
    for (int k = 0; k < 8; k++) begin
      if (gap[k]) begin
        en = 1'b0; rs1 = 4'($urandom); imm = 4'($urandom);
        cyc(mk(4'h0, 1'b0, dat(d0, top, 4 * k), (k > 0) ? res[1:0] : l0, sz));
      end
      if (k == rst_at) begin
        rst = 1'b1; en = 1'b1; rs1 = a[4*k +: 4]; imm = b[4*k +: 4];
        cyc(mk(4'h0, 1'b0, 32'h0, 2'b00, sz));
        rst = 1'b0; en = 1'b0;
        m_data = 32'h0; m_lsb = 2'b00;
        return;
      end
      en = 1'b1; rs1 = a[4*k +: 4]; imm = b[4*k +: 4];
      cyc(mk(qs[4*k +: 4], k == 7, dat(d0, top, 4 * k), (k > 0) ? res[1:0] : l0, sz));
    end
    m_data = dat(d0, top, 32);
    m_lsb  = res[1:0];
    en = 1'b0;
    cyc(mk(4'h0, 1'b0, m_data, m_lsb, sz));
  endtask

  initial begin
    logic [31:0] gd;
    logic [1:0]  gl;
    int          nb, nbits;
    rst = 1'b1; en = 1'b0; init = 1'b0; rs1_en = 1'b0; imm_en = 1'b0; clr_lsb = 1'b0;
    shift_op = 1'b0; rsh = 1'b0; sh_signed = 1'b0; mdu_op = 1'b0; shamt = 2'b00; size = 2'b00;
    rs1 = 4'h0; imm = 4'h0;
    for (int g = 0; g < 3; g++) begin g_en[g] = 1'b0; g_rs1[g] = 8'h0; g_imm[g] = 8'h0; end
    m_data = 32'h0; m_lsb = 2'b00;
    @(posedge clk);
    #1;
    en = 1'b1;
    cyc(mk(4'h0, 1'b0, 32'h0, 2'b00, 2'b00));
    rst = 1'b0; en = 1'b0;
    cyc(mk(4'h0, 1'b0, 32'h0, 2'b00, 2'b00));

    run_word(1, 1, 1, 0, 0, 0, 0, 2'd0, 2'b00, 32'h0000_1000, 32'h0000_0FFF, 0, -1);
    run_word(1, 1, 1, 1, 0, 0, 0, 2'd0, 2'b10, 32'h0000_0004, 32'h0000_0003, 0, -1);
    size = 2'b00;
    cyc(mk(4'h0, 1'b0, m_data, m_lsb, 2'b00));
    run_word(1, 1, 1, 0, 0, 0, 0, 2'd0, 2'b00, 32'h8000_0000, 32'h0, 0, -1);
    run_word(0, 0, 0, 0, 0, 0, 1, 2'd0, 2'b00, 32'h0, 32'h0, 0, -1);
    run_word(1, 1, 1, 0, 0, 0, 0, 2'd0, 2'b00, 32'h8000_0000, 32'h0, 0, -1);
    run_word(0, 0, 0, 0, 0, 0, 0, 2'd0, 2'b00, 32'h0, 32'h0, 0, -1);
    run_word(1, 1, 1, 0, 0, 0, 0, 2'd0, 2'b00, 32'h0000_0001, 32'h0, 0, -1);
    run_word(0, 0, 0, 0, 1, 0, 0, 2'd1, 2'b00, 32'h0, 32'h0, 0, -1);
    run_word(1, 1, 1, 0, 0, 0, 0, 2'd0, 2'b00, 32'h1234_5678, 32'h0FED_CBA9, 0, 3);
    run_word(1, 1, 1, 0, 0, 0, 0, 2'd0, 2'b00, 32'h0000_1000, 32'h0000_0FFF, 0, -1);

    for (int i = 0; i < 150; i++) begin
      run_word(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               1'($urandom), 2'($urandom), 2'($urandom), $urandom, $urandom, 1,
               ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 7)) : -1);
    end

    rst = 1'b1; en = 1'b0;
    cyc(mk(4'h0, 1'b0, 32'h0, 2'b00, size));
    rst = 1'b0;
    m_data = 32'h0; m_lsb = 2'b00;
    for (int k = 0; k <= 33; k++) begin
      for (int g = 0; g < 3; g++) begin
        nb    = 32 / wg[g];
        nbits = (k < nb ? k : nb) * wg[g];
        g_en[g]  = (k < nb);
        g_rs1[g] = 8'(32'h0000_1000 >> (wg[g] * k));
        g_imm[g] = 8'(32'h0000_0FFF >> (wg[g] * k));
        gd = dat(32'h0, 32'h0000_1FFF, nbits);
        gl = {nbits > 1 ? 1'b1 : 1'b0, nbits > 0 ? 1'b1 : 1'b0};
        gq[g].push_back(mk(4'h0, k == nb - 1, gd, gl, 2'b00));
      end
      cyc(mk(4'h0, 1'b0, m_data, m_lsb, size));
    end

    @(negedge clk);
    #1;
    if (mq.size() != 0 || gq[0].size() != 0 || gq[1].size() != 0 || gq[2].size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: expectations left unchecked %0d %0d %0d %0d",
               mq.size(), gq[0].size(), gq[1].size(), gq[2].size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
